// File: rtl/pong_pkg.sv
// Shared geometry constants and game state encoding for the SpeedPong engine.
package pong_pkg;

   localparam int unsigned COORD_W    = 10;
   localparam int unsigned FIELD_TOP  = 10;
   localparam int unsigned FIELD_BOT  = 471;
   localparam int unsigned P1_FACE_X  = 75;
   localparam int unsigned P2_FACE_X  = 565;
   localparam int unsigned BALL_Y1    = 225;
   localparam int unsigned BALL_Y2    = 255;
   localparam int unsigned SCREEN_W   = 640;
   localparam int unsigned PAD_RST_Y1 = 200;

   typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_t;

endpackage

// File: rtl/pong_paddle.sv
// One paddle: steps up/down once per frame, clamped to the playing field.
module pong_paddle
   import pong_pkg::*;
#(
   parameter int unsigned PAD_H    = 80,
   parameter int unsigned PAD_STEP = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               freeze,
   input  logic               restore,
   input  logic               up,
   input  logic               dn,
   output logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] y2
);

   localparam logic [COORD_W-1:0] Y_MIN  = COORD_W'(FIELD_TOP);
   localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(FIELD_BOT - PAD_H);
   localparam logic [COORD_W-1:0] STEP   = COORD_W'(PAD_STEP);
   localparam logic [COORD_W-1:0] HEIGHT = COORD_W'(PAD_H);
   localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(PAD_RST_Y1);

   logic [COORD_W-1:0] y1_nx;

   always_comb begin
      y1_nx = y1;
      if (up && !dn)
         y1_nx = (y1 >= Y_MIN + STEP) ? y1 - STEP : Y_MIN;
      else if (dn && !up)
         y1_nx = (y1 + STEP <= Y_MAX) ? y1 + STEP : Y_MAX;
   end

   // y2 is kept as its own register so both edges come straight from flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y1 <= Y_RST;
         y2 <= Y_RST + HEIGHT;
      end else if (restore) begin
         y1 <= Y_RST;
         y2 <= Y_RST + HEIGHT;
      end else if (frame_tick && !freeze) begin
         y1 <= y1_nx;
         y2 <= y1_nx + HEIGHT;
      end
   end

endmodule

// File: rtl/pong_engine.sv
// SpeedPong game-state engine: paddles, horizontal ball, hits, scoring, pause and game over.
// Define SPEEDUP_EN to raise ball speed by one on every paddle hit (saturating at MAX_SPEED).
module pong_engine
   import pong_pkg::*;
#(
   parameter int unsigned PAD_H        = 80,
   parameter int unsigned PAD_STEP     = 4,
   parameter int unsigned BALL_W       = 30,
   parameter int unsigned START_SPEED  = 2,
   parameter int unsigned MAX_SPEED    = 15,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned PAUSE_FRAMES = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               p1_up,
   input  logic               p1_dn,
   input  logic               p2_up,
   input  logic               p2_dn,
   input  logic               serve,
   output logic [COORD_W-1:0] p1y1,
   output logic [COORD_W-1:0] p1y2,
   output logic [COORD_W-1:0] p2y1,
   output logic [COORD_W-1:0] p2y2,
   output logic [COORD_W-1:0] ballx1,
   output logic [COORD_W-1:0] ballx2,
   output logic [3:0]         score1,
   output logic [3:0]         score2,
   output logic [3:0]         speed,
   output logic               game_over
);

   localparam logic [COORD_W-1:0] BW       = COORD_W'(BALL_W);
   localparam logic [COORD_W-1:0] BALL_RST = COORD_W'((SCREEN_W - BALL_W) / 2);
   localparam logic [COORD_W-1:0] BALL_MAX = COORD_W'(SCREEN_W - BALL_W);
   localparam logic [COORD_W-1:0] P1_FACE  = COORD_W'(P1_FACE_X);
   localparam logic [COORD_W-1:0] P2_FACE  = COORD_W'(P2_FACE_X);
   localparam logic [3:0]         SPD_START =
      4'((START_SPEED < MAX_SPEED) ? START_SPEED : MAX_SPEED);
   localparam logic [3:0]         WIN      = 4'(WIN_SCORE);
   localparam logic [7:0]         PAUSE    = 8'(PAUSE_FRAMES);

   state_t      state;
   logic        dir_right;
   logic [7:0]  pause_cnt;
   logic        freeze, restore;
   logic [10:0] nx, nx_right;
   logic        nx_neg, p1_ov, p2_ov, hit1, hit2, miss_l, miss_r;
   logic [3:0]  speed_hit;

   assign freeze  = (state == OVER);
   assign restore = freeze && serve;

   pong_paddle #(.PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad1 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .freeze(freeze),
      .restore(restore), .up(p1_up), .dn(p1_dn), .y1(p1y1), .y2(p1y2)
   );

   pong_paddle #(.PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad2 (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .freeze(freeze),
      .restore(restore), .up(p2_up), .dn(p2_dn), .y1(p2y1), .y2(p2y2)
   );

`ifdef SPEEDUP_EN
   localparam logic [3:0] SPD_MAX = 4'(MAX_SPEED);
   assign speed_hit = (speed >= SPD_MAX) ? SPD_MAX : speed + 4'd1;
`else
   assign speed_hit = SPD_START;
`endif

   // Candidate position in 11 bits: bit 10 set means the ball left through column 0
   always_comb begin
      nx       = dir_right ? {1'b0, ballx1} + 11'(speed) : {1'b0, ballx1} - 11'(speed);
      nx_right = nx + 11'(BALL_W);
      nx_neg   = nx[10];
      p1_ov    = (p1y1 < COORD_W'(BALL_Y2)) && (p1y2 > COORD_W'(BALL_Y1));
      p2_ov    = (p2y1 < COORD_W'(BALL_Y2)) && (p2y2 > COORD_W'(BALL_Y1));
      hit1     = !dir_right && (ballx1 >= P1_FACE) && (nx_neg || nx <= 11'(P1_FACE_X)) && p1_ov;
      hit2     = dir_right && (ballx2 <= P2_FACE) && (nx_right >= 11'(P2_FACE_X)) && p2_ov;
      miss_l   = nx_neg;
      miss_r   = !nx_neg && (nx_right > 11'(SCREEN_W));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ballx1    <= BALL_RST;
         ballx2    <= BALL_RST + BW;
         dir_right <= 1'b1;
         speed     <= SPD_START;
         score1    <= 4'd0;
         score2    <= 4'd0;
         pause_cnt <= 8'd0;
         game_over <= 1'b0;
      end else begin
         case (state)
            IDLE: if (serve) state <= PLAY;
            PLAY: if (frame_tick) begin
               if (hit1) begin
                  ballx1    <= P1_FACE;
                  ballx2    <= P1_FACE + BW;
                  dir_right <= 1'b1;
                  speed     <= speed_hit;
               end else if (hit2) begin
                  ballx1    <= P2_FACE - BW;
                  ballx2    <= P2_FACE;
                  dir_right <= 1'b0;
                  speed     <= speed_hit;
               end else if (miss_l) begin
                  score2    <= score2 + 4'd1;
                  ballx1    <= '0;
                  ballx2    <= BW;
                  dir_right <= 1'b0;
                  pause_cnt <= PAUSE;
                  state     <= POINT;
               end else if (miss_r) begin
                  score1    <= score1 + 4'd1;
                  ballx1    <= BALL_MAX;
                  ballx2    <= BALL_MAX + BW;
                  dir_right <= 1'b1;
                  pause_cnt <= PAUSE;
                  state     <= POINT;
               end else begin
                  ballx1 <= nx[COORD_W-1:0];
                  ballx2 <= nx[COORD_W-1:0] + BW;
               end
            end
            // Direction was already aimed at the loser on entry; only recentre here
            POINT: if (frame_tick) begin
               if (pause_cnt <= 8'd1) begin
                  ballx1 <= BALL_RST;
                  ballx2 <= BALL_RST + BW;
                  speed  <= SPD_START;
                  if (score1 == WIN || score2 == WIN) begin
                     state     <= OVER;
                     game_over <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  pause_cnt <= pause_cnt - 8'd1;
               end
            end
            OVER: if (serve) begin
               state     <= IDLE;
               game_over <= 1'b0;
               ballx1    <= BALL_RST;
               ballx2    <= BALL_RST + BW;
               dir_right <= 1'b1;
               speed     <= SPD_START;
               score1    <= 4'd0;
               score2    <= 4'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
